// File: rtl/dct_2d_sched.sv
// Sequencer that shares one 1-D DCT engine across the row and column passes of an 8x8 2-D DCT.
// Pass-0 results are captured into a transpose buffer. Pass-1 results are written back to it and drained.
module dct_2d_sched #(
  parameter int unsigned SIZE    = 8,
  parameter int unsigned ENG_IN  = 11,
  parameter int unsigned ENG_OUT = 14,
  parameter int unsigned LAT     = 4,
  parameter int unsigned SHIFT   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [8*SIZE-1:0]    in_data,
  input  logic                 approx_en,
  output logic                 eng_valid,
  output logic [8*ENG_IN-1:0]  eng_in,
  output logic                 eng_approx_en,
  input  logic [8*ENG_OUT-1:0] eng_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8*ENG_OUT-1:0] out_data,
  output logic                 busy
);

  typedef enum logic [2:0] {StLoad, StRowWait, StColIssue, StColWait, StDrain} state_e;

  localparam logic signed [ENG_OUT-1:0] SatMax = ENG_OUT'((1 << (ENG_IN - 1)) - 1);
  localparam logic signed [ENG_OUT-1:0] SatMin = ~SatMax;

  state_e              state_q, state_d;
  logic [2:0]          row_cnt_q, row_cnt_d;
  logic [2:0]          col_cnt_q, col_cnt_d;
  logic [2:0]          drain_cnt_q, drain_cnt_d;
  // Bit 3 selects the pass: captures 0..7 are rows, 8..15 are columns.
  logic [3:0]          cap_cnt_q;
  logic [LAT-1:0]      vsr_q;
  logic                eng_valid_q, eng_valid_d;
  logic [8*ENG_IN-1:0] eng_in_q, eng_in_d;
  logic                approx_q, approx_d;
  logic                cap_en;
  logic [ENG_OUT-1:0]  mem_q [8][8];

  function automatic logic [ENG_IN-1:0] sat_shift(input logic [ENG_OUT-1:0] v);
    logic signed [ENG_OUT-1:0] s;
    s = $signed(v) >>> SHIFT;
    if (s > SatMax) s = SatMax;
    else if (s < SatMin) s = SatMin;
    return s[ENG_IN-1:0];
  endfunction

  assign cap_en        = vsr_q[LAT-1];
  assign in_ready      = (state_q == StLoad);
  assign out_valid     = (state_q == StDrain);
  assign busy          = !((state_q == StLoad) && (row_cnt_q == 3'd0));
  assign eng_valid     = eng_valid_q;
  assign eng_in        = eng_in_q;
  assign eng_approx_en = approx_q;

  always_comb begin
    state_d     = state_q;
    row_cnt_d   = row_cnt_q;
    col_cnt_d   = col_cnt_q;
    drain_cnt_d = drain_cnt_q;
    eng_valid_d = 1'b0;
    eng_in_d    = eng_in_q;
    approx_d    = approx_q;
    unique case (state_q)
      StLoad: begin
        if (in_valid) begin
          eng_valid_d = 1'b1;
          for (int i = 0; i < 8; i++) begin
            eng_in_d[i*ENG_IN +: ENG_IN] = ENG_IN'($signed(in_data[i*SIZE +: SIZE]));
          end
          if (row_cnt_q == 3'd0) approx_d = approx_en;
          row_cnt_d = row_cnt_q + 3'd1;
          if (row_cnt_q == 3'd7) state_d = StRowWait;
        end
      end
      StRowWait: begin
        if (cap_en && (cap_cnt_q == 4'd7)) state_d = StColIssue;
      end
      StColIssue: begin
        eng_valid_d = 1'b1;
        for (int r = 0; r < 8; r++) begin
          eng_in_d[r*ENG_IN +: ENG_IN] = sat_shift(mem_q[r][col_cnt_q]);
        end
        col_cnt_d = col_cnt_q + 3'd1;
        if (col_cnt_q == 3'd7) state_d = StColWait;
      end
      StColWait: begin
        if (cap_en && (cap_cnt_q == 4'd15)) state_d = StDrain;
      end
      StDrain: begin
        if (out_ready) begin
          drain_cnt_d = drain_cnt_q + 3'd1;
          if (drain_cnt_q == 3'd7) state_d = StLoad;
        end
      end
      default: state_d = StLoad;
    endcase
  end

  always_comb begin
    out_data = '0;
    for (int c = 0; c < 8; c++) begin
      out_data[c*ENG_OUT +: ENG_OUT] = mem_q[drain_cnt_q][c];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StLoad;
      row_cnt_q   <= 3'd0;
      col_cnt_q   <= 3'd0;
      drain_cnt_q <= 3'd0;
      cap_cnt_q   <= 4'd0;
      vsr_q       <= '0;
      eng_valid_q <= 1'b0;
      eng_in_q    <= '0;
      approx_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_cnt_q   <= row_cnt_d;
      col_cnt_q   <= col_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      vsr_q       <= (vsr_q << 1) | LAT'(eng_valid_q);
      eng_valid_q <= eng_valid_d;
      eng_in_q    <= eng_in_d;
      approx_q    <= approx_d;
      if (cap_en) cap_cnt_q <= cap_cnt_q + 4'd1;
    end
  end

  // Buffer contents need no reset; stale data is always overwritten before use.
  always_ff @(posedge clk) begin
    if (cap_en) begin
      for (int i = 0; i < 8; i++) begin
        if (!cap_cnt_q[3]) mem_q[cap_cnt_q[2:0]][i] <= eng_out[i*ENG_OUT +: ENG_OUT];
        else               mem_q[i][cap_cnt_q[2:0]] <= eng_out[i*ENG_OUT +: ENG_OUT];
      end
    end
  end

endmodule
